uart_prog_loader: RTL
=====================

# uart_prog_loader

Boot-time program loader between the UART byte receiver and instruction memory. Assembles received bytes into 32-bit little-endian words, writes them to consecutive instruction-memory words, and holds the CPU core in reset until CELL_NUMBERS words are loaded. Once released, the core fetches from address 0 and ignores further UART traffic.

## Interface

- CELL_NUMBERS, 16: number of 32-bit words to load; must be ≥1.
- ADDR_W, 8: word-address width; 2^ADDR_W ≥ CELL_NUMBERS.

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte from UART receiver.
- rx_valid  input  1  one-cycle strobe, rx_data valid this cycle.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  output  ADDR_W  word address of write.
- mem_wdata  output  32  word to write.
- cpu_rst  output  1  core reset hold; high while loading.
- done  output  1  load complete, core running.
- error  output  1  checksum mismatch (see Configuration).

## Operation

- States: LOAD, CHECK (only with macro), RUN, ERR (only with macro).
- Reset: state=LOAD, byte_idx=0, word_idx=0, shift reg=0, sum=0. Outputs: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, error=0.
- LOAD: each rx_valid stores rx_data into byte lane byte_idx (byte 0 → bits [7:0], byte 3 → bits [31:24]) and increments byte_idx mod 4.
- On the 4th byte: register the full word onto mem_wdata, word_idx onto mem_addr, pulse mem_we; word_idx increments.
- When the written word is word CELL_NUMBERS-1: go to RUN (without macro) or CHECK (with macro).
- RUN: cpu_rst=0, done=1; rx_valid ignored; no further mem_we. Remains until rst.
- rx_data is ignored when rx_valid=0. mem_addr and mem_wdata hold their last values between writes.
- Address never wraps: loading stops at CELL_NUMBERS; later bytes are dropped.
- rst in any state (mid-word, mid-load, RUN, ERR) returns to the reset state. Partial word is discarded and cpu_rst reasserts in the cycle after rst is sampled.

## Timing

- Latency: mem_we is high in cycle N+1 when the 4th byte's rx_valid is in cycle N.
- Back-to-back rx_valid every cycle must be accepted. rx_valid coinciding with mem_we is captured as byte 0 of the next word.
- Without macro: done=1 and cpu_rst=0 from cycle N+2, one cycle after the final mem_we. Memory write is complete before core release.
- With macro: checksum byte strobed in cycle M gives done=1 / cpu_rst=0, or error=1, in cycle M+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) of all data bytes is kept during LOAD.
  - After the last word, CHECK waits for one extra byte.
  - Byte equals sum → RUN.
  - Byte differs → ERR: error=1, cpu_rst=1, done=0, rx ignored until rst.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK/ERR states, no sum register.
  - error is tied 0; LOAD goes directly to RUN after the last word.

## Test plan

- Reset then 4 bytes 0x13,0x00,0x00,0x00 (CELL_NUMBERS=1, no macro) → one mem_we, mem_addr=0, mem_wdata=0x00000013. Next cycle done=1, cpu_rst=0.
- CELL_NUMBERS=3, 12 bytes with rx_valid every cycle → mem_we at addrs 0,1,2 exactly 4 cycles apart, words little-endian correct, no dropped byte.
- After RUN, 8 more bytes → no mem_we, done stays 1, mem_addr stays CELL_NUMBERS-1.
- rst asserted after 2 bytes of word 1 → cpu_rst=1 next cycle. Reloading 4 bytes 0xAA,0xBB,0xCC,0xDD writes 0xDDCCBBAA to addr 0.
- Macro on, CELL_NUMBERS=1, bytes 0x01,0x02,0x03,0x04, then checksum 0x0A → done=1. Checksum 0x0B instead → error=1, cpu_rst=1, done=0 until rst.
- rx_valid=0 with toggling rx_data over 50 cycles → no state change, mem_we never asserted.

Source files
------------

// File: rtl/uart_prog_loader.sv
// Boot loader: packs UART bytes into little-endian 32-bit words, writes them to instruction
// memory and holds the core in reset until loaded. Optional checksum byte: LOADER_CHECKSUM_EN.
module uart_prog_loader #(
    parameter int CELL_NUMBERS = 16,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [1:0]        state_dbg
);

    // Handshake: rx_valid is a one-cycle strobe with no back-pressure; every strobe seen in
    // LOAD/CHECK is consumed that cycle. mem_we is a one-cycle pulse qualifying mem_addr/mem_wdata.

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd3;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELL_NUMBERS - 1);

    logic [1:0]        state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       shift_q;

    assign state_dbg = state;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       error_q;

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            byte_idx  <= 2'd0;
            word_idx  <= '0;
            shift_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q    <= sum_q + rx_data;
`endif
                        case (byte_idx)
                            2'd0: shift_q[7:0]   <= rx_data;
                            2'd1: shift_q[15:8]  <= rx_data;
                            2'd2: shift_q[23:16] <= rx_data;
                            default: begin
                                // The 4th byte goes straight into the write word, so a strobe
                                // in the mem_we cycle already lands in lane 0 of the next word.
                                mem_we    <= 1'b1;
                                mem_addr  <= word_idx;
                                mem_wdata <= {rx_data, shift_q};
                                word_idx  <= word_idx + 1'b1;
                                if (word_idx == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
                                    state <= S_CHECK;
`else
                                    state <= S_RUN;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == sum_q) begin
                            state   <= S_RUN;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    error_q <= 1'b1;
                end
`endif
                S_RUN: begin
                    // Release lags the last write by a cycle so memory is settled first.
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
